// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory_bus port between the CPU (port 0) and a secondary master (port 1).
// Latency: grant/ack 1 cycle after request sample; read data READ_LATENCY+2 cycles after request sample.
// Backpressure: requesters hold req/address/data until ack; build option ARBITER_ROUND_ROBIN_EN selects round-robin ties.
module memory_arbiter #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_0,
   input  logic        req_1,
   input  logic        we_0,
   input  logic        we_1,
   input  logic [15:0] address_0,
   input  logic [15:0] address_1,
   input  logic [15:0] wdata_0,
   input  logic [15:0] wdata_1,
   output logic        ack_0,
   output logic        ack_1,
   output logic [15:0] rdata_0,
   output logic [15:0] rdata_1,
   output logic        rvalid_0,
   output logic        rvalid_1,
   output logic [15:0] mem_address,
   output logic [15:0] mem_data_in,
   input  logic [15:0] mem_data_out,
   output logic        mem_bus_enable,
   output logic        mem_write_enable,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   // Last WAIT count value; WAIT is never entered when READ_LATENCY is 1.
   localparam int          WAIT_LAST_INT = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
   localparam logic [2:0]  WAIT_LAST     = 3'(WAIT_LAST_INT);

   state_t      state, state_nxt;
   logic        grant, grant_nxt;      // port owning the in-flight transaction
   logic        pick;                  // port chosen in IDLE this cycle
   logic [2:0]  cnt, cnt_nxt;
   logic [15:0] mem_address_nxt, mem_data_in_nxt, rdata_0_nxt, rdata_1_nxt;
   logic        mem_bus_enable_nxt, mem_write_enable_nxt;
   logic        ack_0_nxt, ack_1_nxt, rvalid_0_nxt, rvalid_1_nxt;
`ifdef ARBITER_ROUND_ROBIN_EN
   logic        last_grant, last_grant_nxt;
`endif

   // State, bookkeeping and every output are registered here.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state            <= IDLE;
         grant            <= 1'b0;
         cnt              <= 3'd0;
         mem_address      <= 16'h0000;
         mem_data_in      <= 16'h0000;
         mem_bus_enable   <= 1'b0;
         mem_write_enable <= 1'b0;
         ack_0            <= 1'b0;
         ack_1            <= 1'b0;
         rvalid_0         <= 1'b0;
         rvalid_1         <= 1'b0;
         rdata_0          <= 16'h0000;
         rdata_1          <= 16'h0000;
         busy             <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
         last_grant       <= 1'b1;
`endif
      end else begin
         state            <= state_nxt;
         grant            <= grant_nxt;
         cnt              <= cnt_nxt;
         mem_address      <= mem_address_nxt;
         mem_data_in      <= mem_data_in_nxt;
         mem_bus_enable   <= mem_bus_enable_nxt;
         mem_write_enable <= mem_write_enable_nxt;
         ack_0            <= ack_0_nxt;
         ack_1            <= ack_1_nxt;
         rvalid_0         <= rvalid_0_nxt;
         rvalid_1         <= rvalid_1_nxt;
         rdata_0          <= rdata_0_nxt;
         rdata_1          <= rdata_1_nxt;
         busy             <= (state_nxt != IDLE);
`ifdef ARBITER_ROUND_ROBIN_EN
         last_grant       <= last_grant_nxt;
`endif
      end
   end

   // Next-state and next-output decode; pulses default low, held values default to themselves.
   always_comb begin
      state_nxt            = state;
      grant_nxt            = grant;
      cnt_nxt              = cnt;
      pick                 = 1'b0;
      mem_address_nxt      = mem_address;
      mem_data_in_nxt      = mem_data_in;
      mem_bus_enable_nxt   = 1'b0;
      mem_write_enable_nxt = 1'b0;
      ack_0_nxt            = 1'b0;
      ack_1_nxt            = 1'b0;
      rvalid_0_nxt         = 1'b0;
      rvalid_1_nxt         = 1'b0;
      rdata_0_nxt          = rdata_0;
      rdata_1_nxt          = rdata_1;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_grant_nxt       = last_grant;
`endif
      case (state)
         IDLE: begin
            if (req_0 || req_1) begin
`ifdef ARBITER_ROUND_ROBIN_EN
               pick           = (req_0 && req_1) ? ~last_grant : req_1;
               last_grant_nxt = pick;
`else
               pick           = ~req_0;
`endif
               grant_nxt            = pick;
               mem_address_nxt      = pick ? address_1 : address_0;
               mem_data_in_nxt      = pick ? wdata_1 : wdata_0;
               mem_write_enable_nxt = pick ? we_1 : we_0;
               mem_bus_enable_nxt   = 1'b1;
               ack_0_nxt            = ~pick;
               ack_1_nxt            = pick;
               state_nxt            = ACCESS;
            end
         end
         ACCESS: begin
            // mem_write_enable mirrors the latched direction during ACCESS.
            if (mem_write_enable) begin
               state_nxt = IDLE;
            end else if (READ_LATENCY > 1) begin
               mem_bus_enable_nxt = 1'b1;
               cnt_nxt            = 3'd0;
               state_nxt          = WAIT;
            end else begin
               state_nxt = DONE;
            end
         end
         WAIT: begin
            if (cnt == WAIT_LAST) begin
               state_nxt = DONE;
            end else begin
               mem_bus_enable_nxt = 1'b1;
               cnt_nxt            = cnt + 3'd1;
            end
         end
         DONE: begin
            if (grant) begin
               rdata_1_nxt  = mem_data_out;
               rvalid_1_nxt = 1'b1;
            end else begin
               rdata_0_nxt  = mem_data_out;
               rvalid_0_nxt = 1'b1;
            end
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter that shares the single `memory_bus` port between the F100-L CPU (port 0) and a secondary bus master such as a DMA/SPI loader (port 1). It serialises requests, drives `address`, `data_in`, `bus_enable` and `write_enable` into `memory_bus`, and returns read data after the memory's fixed read latency. It sits between the masters and `memory_bus`, clocked on the CPU `clk`.

## Interface

- `READ_LATENCY`, 1: cycles from address presented to `mem_data_out` valid. Legal range 1..4.
- `clk`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_0`, `req_1`  in  1  access request. Must be held with its address/data until the matching `ack`.
- `we_0`, `we_1`  in  1  1 = write, 0 = read; qualified by `req_x`.
- `address_0`, `address_1`  in  16  request address.
- `wdata_0`, `wdata_1`  in  16  write data.
- `ack_0`, `ack_1`  out  1  one-cycle pulse: request latched and issued.
- `rdata_0`, `rdata_1`  out  16  read data; held until that port's next read completes.
- `rvalid_0`, `rvalid_1`  out  1  one-cycle pulse: `rdata_x` updated.
- `mem_address`  out  16  to `memory_bus.address`.
- `mem_data_in`  out  16  to `memory_bus.data_in`.
- `mem_data_out`  in  16  from `memory_bus.data_out`.
- `mem_bus_enable`  out  1  to `memory_bus.bus_enable`.
- `mem_write_enable`  out  1  to `memory_bus.write_enable`.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- States: IDLE, ACCESS, WAIT, DONE. All outputs registered.
- IDLE: if any `req_x` is high, pick a winner, latch its address, wdata and we into `mem_*`, and go to ACCESS. Otherwise stay.
- ACCESS (1 cycle):
  - Assert `mem_bus_enable` and pulse the winner's `ack_x`.
  - Write: `mem_write_enable`=1 for this cycle only, then go to IDLE.
  - Read: `mem_write_enable`=0. Go to WAIT if `READ_LATENCY`>1, else DONE.
- WAIT: a 3-bit counter counts `READ_LATENCY`-1 cycles. `mem_bus_enable` stays high and `mem_address` stays stable. Then go to DONE.
- DONE: capture `mem_data_out` into the winner's `rdata_x`, pulse its `rvalid_x` on the next cycle, and return to IDLE. `mem_bus_enable` is 0.
- `mem_address` and `mem_data_in` hold their last value when idle. `mem_write_enable` is never high outside ACCESS.
- `req_x` dropping after latch is ignored; the latched transaction completes. A requester that drops `req_x` before `ack_x` loses the request, with no side effect.
- Both `rvalid` outputs are never high in the same cycle. `ack_x` and `rvalid_x` go only to the winner.
- Reset: state=IDLE. Every output is 0, including `rdata_x`. `last_grant`=1. Any in-flight transaction is aborted with no `ack`/`rvalid`. A write aborted in ACCESS may already have been committed to memory.

## Timing

- Request sampled high in IDLE at edge N:
  - ACCESS, `ack` and `mem_bus_enable` are high in cycle N+1.
- Write: bus occupied 1 cycle. Back in IDLE at N+2; next grant drives at N+3. Peak throughput is 1 write per 2 cycles.
- Read: `mem_data_out` is sampled in cycle N+`READ_LATENCY`+1 (DONE). `rvalid_x`/`rdata_x` appear in cycle N+`READ_LATENCY`+2, the same cycle the FSM is back in IDLE. Read-to-data latency from request sample is `READ_LATENCY`+2 cycles.
- A new request sampled in the IDLE cycle that carries `rvalid` is issued the following cycle; there are no extra bubbles.

## Configuration

- `ARBITER_ROUND_ROBIN_EN` defined:
  - When both `req` are high in IDLE, grant the port not equal to `last_grant`.
  - `last_grant` updates on every grant. Reset value 1, so port 0 wins the first tie.
- Undefined: fixed priority; port 0 always wins ties and `last_grant` logic is removed. Port 1 can starve while port 0 requests back-to-back.

## Test plan

- Port 0 write 0x1234 to 0x0010 -> `ack_0` pulse at N+1, `mem_write_enable`=1 for exactly one cycle, `mem_data_in`=0x1234. Port 0 read of 0x0010 with `READ_LATENCY`=1 -> `rvalid_0` at N+3, `rdata_0`=0x1234.
- `READ_LATENCY`=3, port 1 read 0x6005 returning 0xBEEF -> `mem_address` stable for 3 cycles, `rvalid_1` at N+5, `rdata_1`=0xBEEF, `rdata_0` unchanged.
- Both ports request continuously, round-robin build -> grants alternate 0,1,0,1. Fixed-priority build -> port 0 is granted every time, `ack_1` never pulses.
- `reset` asserted low during WAIT of a port 0 read -> next cycle all outputs 0, no `rvalid_0`. After release, a fresh port 0 request is acked normally.
- Port 0 read completing while port 1 is already requesting -> `rvalid_0` and port 1 ACCESS occur on consecutive cycles, and `mem_write_enable` never glitches.
- Port 1 drops `req_1` before `ack_1` -> no bus activity, `busy` stays 0.
